// File: rtl/gcd_pkg.sv
// Shared constants and types for the GCD operand dispatcher.
// TIMEOUT_CYC is only consumed when GCD_DISPATCH_TIMEOUT_EN is defined.
package gcd_pkg;

    localparam int GCD_W = 8;
    localparam logic [7:0] TIMEOUT_CYC = 8'd200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CLR,
        ST_WAIT_DONE
    } disp_state_e;

    // gcd(0,x)=x and gcd(0,0)=0, so a zero-operand job resolves to the OR of its operands
    function automatic logic [GCD_W-1:0] zero_bypass_res(input logic [GCD_W-1:0] u,
                                                         input logic [GCD_W-1:0] v);
        return u | v;
    endfunction

endpackage

// File: rtl/gcd_dispatch_if.sv
// Request, core-load and result signals of the GCD dispatcher.
// timeout_err exists only when GCD_DISPATCH_TIMEOUT_EN is defined.
interface gcd_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_u;
    logic [7:0]       in_v;
    logic [TAG_W-1:0] in_tag;
    logic [7:0]       core_u;
    logic [7:0]       core_v;
    logic             core_ld;
    logic [7:0]       core_res;
    logic             core_done;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_res;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             busy;
`ifdef GCD_DISPATCH_TIMEOUT_EN
    logic             timeout_err;

    modport slave (
        input  in_valid, in_u, in_v, in_tag, core_res, core_done, out_ready,
        output in_ready, core_u, core_v, core_ld, out_valid, out_res, out_tag, out_zero,
        output busy, timeout_err
    );
    modport master (
        output in_valid, in_u, in_v, in_tag, core_res, core_done, out_ready,
        input  in_ready, core_u, core_v, core_ld, out_valid, out_res, out_tag, out_zero,
        input  busy, timeout_err
    );
`else
    modport slave (
        input  in_valid, in_u, in_v, in_tag, core_res, core_done, out_ready,
        output in_ready, core_u, core_v, core_ld, out_valid, out_res, out_tag, out_zero,
        output busy
    );
    modport master (
        output in_valid, in_u, in_v, in_tag, core_res, core_done, out_ready,
        input  in_ready, core_u, core_v, core_ld, out_valid, out_res, out_tag, out_zero,
        input  busy
    );
`endif
endinterface

// File: rtl/gcd_req_fifo.sv
// Request FIFO for the GCD dispatcher: DEPTH entries (power of 2), show-ahead head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module gcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/gcd_dispatch.sv
// Feeds queued (u,v,tag) jobs to the 8-bit binary GCD core one at a time and returns results in order.
// Optional watchdog enabled by defining GCD_DISPATCH_TIMEOUT_EN (adds bus.timeout_err).
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          resetb,
    gcd_dispatch_if.slave bus
);
    localparam int FW = 2 * GCD_W + TAG_W;

    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic [GCD_W-1:0] head_u;
    logic [GCD_W-1:0] head_v;
    logic [TAG_W-1:0] head_tag;
    logic             head_zero;

    disp_state_e      state_q, state_d;
    logic [GCD_W-1:0] core_u_q, core_v_q;
    logic [TAG_W-1:0] job_tag_q;
    logic             out_valid_q, out_valid_d;
    logic [GCD_W-1:0] out_res_q, out_res_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_zero_q, out_zero_d;
    logic             core_ld;

    logic             slot_free;
    logic             fire_byp;
    logic             fire_issue;
    logic             fire_done;
    logic             fire_to;

    assign fifo_push = bus.in_valid && !fifo_full;
    assign fifo_din  = {bus.in_tag, bus.in_u, bus.in_v};

    gcd_req_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign head_v    = fifo_dout[GCD_W-1:0];
    assign head_u    = fifo_dout[2*GCD_W-1:GCD_W];
    assign head_tag  = fifo_dout[FW-1:2*GCD_W];
    assign head_zero = (head_u == '0) || (head_v == '0);

    assign slot_free  = !out_valid_q || bus.out_ready;
    assign fire_byp   = (state_q == ST_IDLE) && !fifo_empty && head_zero && slot_free;
    assign fire_issue = (state_q == ST_IDLE) && !fifo_empty && !head_zero;
    assign fire_done  = (state_q == ST_WAIT_DONE) && bus.core_done && slot_free;
    assign fifo_pop   = fire_byp || fire_issue;

`ifdef GCD_DISPATCH_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       timeout_err_q;
    logic       waiting;

    assign waiting = (state_q == ST_WAIT_CLR) || (state_q == ST_WAIT_DONE);
    // A genuine completion in the same cycle wins over the watchdog
    assign fire_to = waiting && (wd_q == TIMEOUT_CYC - 8'd1) && slot_free && !fire_done;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE)
                wd_q <= '0;
            else if (waiting && wd_q != TIMEOUT_CYC - 8'd1)
                wd_q <= wd_q + 8'd1;
            if (fire_to) timeout_err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign fire_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (fire_issue) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                // done still high here belongs to the previous job
                if (fire_to)             state_d = ST_IDLE;
                else if (!bus.core_done) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (fire_done || fire_to) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_ld = (state_q == ST_ISSUE);
    end

    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        out_res_d   = out_res_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
        if (fire_byp) begin
            out_valid_d = 1'b1;
            out_res_d   = zero_bypass_res(head_u, head_v);
            out_tag_d   = head_tag;
            out_zero_d  = 1'b1;
        end else if (fire_done) begin
            out_valid_d = 1'b1;
            out_res_d   = bus.core_res;
            out_tag_d   = job_tag_q;
            out_zero_d  = 1'b0;
        end else if (fire_to) begin
            out_valid_d = 1'b1;
            out_res_d   = '0;
            out_tag_d   = job_tag_q;
            out_zero_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            core_u_q    <= '0;
            core_v_q    <= '0;
            job_tag_q   <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            // Operands stay put until the next issue; the core samples them after ld
            if (fire_issue) begin
                core_u_q  <= head_u;
                core_v_q  <= head_v;
                job_tag_q <= head_tag;
            end
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.core_u    = core_u_q;
    assign bus.core_v    = core_v_q;
    assign bus.core_ld   = core_ld;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.busy      = !fifo_empty || (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Randomised self-checking bench for gcd_dispatch with a behavioural GCD core and an in-order scoreboard.
module tb_gcd_dispatch;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    gcd_dispatch_if #(.TAG_W(TAG_W)) bus ();

    gcd_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    int lat_mode = 0;   // 0: short random core latency, 1: long fixed latency
    int ld_cnt   = 0;
    int last_res = -1, last_tag = -1, last_zero = -1;

    typedef struct {int res; int tag; int zero;} exp_t;
    typedef struct {int u; int v;} ops_t;
    exp_t sb[$];
    ops_t ldq[$];

    function automatic int gcd_ref(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Behavioural GCD core: samples operands one cycle after ld, clears done then, sets it later
    logic       pend_q, run_q, cdone_q;
    logic [7:0] cu_q, cv_q, cres_q;
    int         cnt_q;
    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            cdone_q <= 1'b0;
            cu_q    <= '0;
            cv_q    <= '0;
            cres_q  <= '0;
            cnt_q   <= 0;
        end else begin
            pend_q <= bus.core_ld;
            if (pend_q) begin
                cu_q    <= bus.core_u;
                cv_q    <= bus.core_v;
                cdone_q <= 1'b0;
                run_q   <= 1'b1;
                cnt_q   <= (lat_mode == 1) ? 40 : int'($urandom_range(0, 4));
            end else if (run_q) begin
                if (cnt_q == 0) begin
                    cdone_q <= 1'b1;
                    cres_q  <= 8'(gcd_ref(int'(cu_q), int'(cv_q)));
                    run_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1;
                end
            end
        end
    end
    assign bus.core_done = cdone_q;
    assign bus.core_res  = cres_q;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Compare process: scoreboard, handshake stability and core-load checks, every cycle
    initial begin
        logic       prev_valid = 1'b0, prev_rdy = 1'b0, prev_ld = 1'b0, prev_zero = 1'b0;
        logic [7:0] prev_res = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        exp_t e;
        ops_t o;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                prev_valid = 1'b0;
                prev_ld    = 1'b0;
                continue;
            end
            if (sb.size() != 0) chk("busy_outstanding", int'(bus.busy), 1);
            else                chk("no_spurious_valid", int'(bus.out_valid), 0);
            if (prev_valid && !prev_rdy) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_res", int'(bus.out_res), int'(prev_res));
                chk("hold_tag", int'(bus.out_tag), int'(prev_tag));
                chk("hold_zero", int'(bus.out_zero), int'(prev_zero));
            end
            if (bus.core_ld) begin
                ld_cnt++;
                chk("ld_one_cycle", int'(prev_ld), 0);
                if (ldq.size() == 0) fail_now("ld_unexpected");
                else begin
                    o = ldq.pop_front();
                    chk("core_u", int'(bus.core_u), o.u);
                    chk("core_v", int'(bus.core_v), o.v);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) fail_now("result_unexpected");
                else begin
                    e = sb.pop_front();
                    chk("out_res", int'(bus.out_res), e.res);
                    chk("out_tag", int'(bus.out_tag), e.tag);
                    chk("out_zero", int'(bus.out_zero), e.zero);
                end
                last_res  = int'(bus.out_res);
                last_tag  = int'(bus.out_tag);
                last_zero = int'(bus.out_zero);
            end
            if (bus.in_valid && bus.in_ready) begin
                e.res  = gcd_ref(int'(bus.in_u), int'(bus.in_v));
                e.tag  = int'(bus.in_tag);
                e.zero = (bus.in_u == 0 || bus.in_v == 0) ? 1 : 0;
                sb.push_back(e);
                if (e.zero == 0) begin
                    o.u = int'(bus.in_u);
                    o.v = int'(bus.in_v);
                    ldq.push_back(o);
                end
            end
            prev_valid = bus.out_valid;
            prev_rdy   = bus.out_ready;
            prev_ld    = bus.core_ld;
            prev_res   = bus.out_res;
            prev_tag   = bus.out_tag;
            prev_zero  = bus.out_zero;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input int v, input int tag);
        logic acc;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.in_u     = 8'(u);
        bus.in_v     = 8'(v);
        bus.in_tag   = TAG_W'(tag);
        do begin
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        if (!acc) fail_now("push_timeout");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 4000; i++) begin
            if (sb.size() == 0 && ldq.size() == 0 && !bus.busy) return;
            tick();
        end
        fail_now(nm);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_core_ld"}, int'(bus.core_ld), 0);
        chk({nm, "_core_u"}, int'(bus.core_u), 0);
        chk({nm, "_core_v"}, int'(bus.core_v), 0);
        chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
        chk({nm, "_out_res"}, int'(bus.out_res), 0);
        chk({nm, "_out_tag"}, int'(bus.out_tag), 0);
        chk({nm, "_out_zero"}, int'(bus.out_zero), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int ld0, u, v;
        bus.in_valid = 1'b0;
        bus.in_u     = '0;
        bus.in_v     = '0;
        bus.in_tag   = '0;

        chk("model_12_18", gcd_ref(12, 18), 6);
        chk("model_0_9", gcd_ref(0, 9), 9);
        chk("model_0_0", gcd_ref(0, 0), 0);
        chk("model_7_13", gcd_ref(7, 13), 1);

        repeat (3) tick();
        check_reset_values("reset");
        resetb = 1'b1;
        tick();

        ld0 = ld_cnt;
        push(12, 18, 3);
        drain("single_drain");
        chk("single_res", last_res, 6);
        chk("single_tag", last_tag, 3);
        chk("single_zero", last_zero, 0);
        chk("single_lds", ld_cnt - ld0, 1);
        $display("txn single: res=%0d tag=%0d zero=%0d", last_res, last_tag, last_zero);

        ld0 = ld_cnt;
        push(0, 9, 1);
        push(0, 0, 2);
        drain("bypass_drain");
        chk("bypass_last_res", last_res, 0);
        chk("bypass_last_zero", last_zero, 1);
        chk("bypass_lds", ld_cnt - ld0, 0);
        $display("txn bypass: last res=%0d tag=%0d", last_res, last_tag);

        ld0 = ld_cnt;
        push(48, 36, 0);
        push(0, 5, 1);
        push(7, 13, 2);
        drain("order_drain");
        chk("order_last_res", last_res, 1);
        chk("order_last_tag", last_tag, 2);
        chk("order_lds", ld_cnt - ld0, 2);
        $display("txn order: last res=%0d tag=%0d", last_res, last_tag);

        lat_mode = 1;
        rdy_mode = 1;
        tick();
        for (int i = 0; i < 5; i++) push($urandom_range(1, 255), $urandom_range(1, 255), i);
        tick();
        chk("bp_in_ready_low", int'(bus.in_ready), 0);
        chk("bp_busy", int'(bus.busy), 1);
        lat_mode = 0;
        rdy_mode = 2;
        drain("bp_drain");
        $display("txn backpressure: drained, last res=%0d tag=%0d", last_res, last_tag);

        for (int i = 0; i < 60; i++) begin
            u = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
            v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
            push(u, v, int'($urandom_range(0, 15)));
            $display("txn random %0d: u=%0d v=%0d", i, u, v);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("random_drain");
        rdy_mode = 0;

        lat_mode = 1;
        push(100, 75, 5);
        repeat (10) tick();
        resetb = 1'b0;
        #1;
        check_reset_values("midjob");
        sb.delete();
        ldq.delete();
        tick();
        tick();
        resetb   = 1'b1;
        lat_mode = 0;
        tick();
        push(255, 85, 7);
        drain("after_reset_drain");
        chk("after_reset_res", last_res, 85);
        chk("after_reset_tag", last_tag, 7);
        $display("txn after reset: res=%0d tag=%0d", last_res, last_tag);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
